// File: rtl/fp_tree_lane_fork.sv
// Forks one wide beat of DATA_SIZE packed fp16 lanes into per-lane streams for the adder tree.
// Optional FORK_LANE_MASK_EN adds a per-beat lane_mask that zeroes masked lanes' tdata.
module fp_tree_lane_fork #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_SIZE  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  // Every stream handshake completes on a clk edge where tvalid and tready are both high;
  // a valid beat holds tdata stable until taken.
  input  logic [DATA_SIZE*DATA_WIDTH-1:0] din_s_tdata,
  input  logic                            din_s_tvalid,
  output logic                            din_s_tready,
`ifdef FORK_LANE_MASK_EN
  input  logic [DATA_SIZE-1:0]            lane_mask,
`endif
  output logic [DATA_SIZE*DATA_WIDTH-1:0] dout_s_tdata,
  output logic [DATA_SIZE-1:0]            dout_s_tvalid,
  input  logic [DATA_SIZE-1:0]            dout_s_tready,
  output logic [CNT_WIDTH-1:0]            beat_cnt,
  output logic                            busy
);

  localparam int W = DATA_SIZE * DATA_WIDTH;

  logic [1:0]           count_q, count_d, cnt_after_pop;
  logic [W-1:0]         e0_q, e0_d, e1_q, e1_d;
  logic [DATA_SIZE-1:0] done_q, done_d, take, lane_valid;
  logic                 ready_q, busy_q;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 have, push, retire;
`ifdef FORK_LANE_MASK_EN
  logic [DATA_SIZE-1:0] m0_q, m0_d, m1_q, m1_d;
`endif

  always_comb begin
    have          = (count_q != 2'd0);
    lane_valid    = {DATA_SIZE{have}} & ~done_q;
    take          = lane_valid & dout_s_tready;
    retire        = have & (&(done_q | take));
    push          = din_s_tvalid & ready_q;
    cnt_after_pop = count_q - {1'b0, retire};
    count_d       = cnt_after_pop + {1'b0, push};
    done_d        = retire ? '0 : (done_q | take);
    beat_cnt_d    = beat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, retire};
    // Pop shifts E1 forward first; a push then lands in whichever slot is the new tail.
    e0_d          = retire ? e1_q : e0_q;
    e1_d          = e1_q;
`ifdef FORK_LANE_MASK_EN
    m0_d          = retire ? m1_q : m0_q;
    m1_d          = m1_q;
`endif
    if (push) begin
      if (cnt_after_pop == 2'd0) begin
        e0_d = din_s_tdata;
`ifdef FORK_LANE_MASK_EN
        m0_d = lane_mask;
`endif
      end else begin
        e1_d = din_s_tdata;
`ifdef FORK_LANE_MASK_EN
        m1_d = lane_mask;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q    <= 2'd0;
      e0_q       <= '0;
      e1_q       <= '0;
      done_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
`ifdef FORK_LANE_MASK_EN
      m0_q       <= '0;
      m1_q       <= '0;
`endif
    end else begin
      count_q    <= count_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      done_q     <= done_d;
      // Registered ready is computed from next count, so a full buffer never sees a push.
      ready_q    <= (count_d < 2'd2);
      busy_q     <= (count_d != 2'd0);
      beat_cnt_q <= beat_cnt_d;
`ifdef FORK_LANE_MASK_EN
      m0_q       <= m0_d;
      m1_q       <= m1_d;
`endif
    end
  end

`ifdef FORK_LANE_MASK_EN
  for (genvar i = 0; i < DATA_SIZE; i++) begin : g_lane
    assign dout_s_tdata[i*DATA_WIDTH +: DATA_WIDTH] =
      m0_q[i] ? '0 : e0_q[i*DATA_WIDTH +: DATA_WIDTH];
  end
`else
  assign dout_s_tdata = e0_q;
`endif

  assign dout_s_tvalid = lane_valid;
  assign din_s_tready  = ready_q;
  assign beat_cnt      = beat_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fp_tree_lane_fork.sv
// Directed bench for fp_tree_lane_fork: reset, streaming, single-lane stall, staggered readies, reset mid-stall.
module tb_fp_tree_lane_fork;
  localparam int DW = 16;
  localparam int DS = 16;
  localparam int CW = 32;
  localparam int W  = DS * DW;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic [W-1:0]  din_s_tdata;
  logic          din_s_tvalid;
  logic          din_s_tready;
  logic [W-1:0]  dout_s_tdata;
  logic [DS-1:0] dout_s_tvalid;
  logic [DS-1:0] dout_s_tready;
  logic [CW-1:0] beat_cnt;
  logic          busy;
`ifdef FORK_LANE_MASK_EN
  logic [DS-1:0] lane_mask;
`endif

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q [DS][$];

  // clock / reset block
  always #5 clk = ~clk;

  fp_tree_lane_fork #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .din_s_tdata  (din_s_tdata),
    .din_s_tvalid (din_s_tvalid),
    .din_s_tready (din_s_tready),
`ifdef FORK_LANE_MASK_EN
    .lane_mask    (lane_mask),
`endif
    .dout_s_tdata (dout_s_tdata),
    .dout_s_tvalid(dout_s_tvalid),
    .dout_s_tready(dout_s_tready),
    .beat_cnt     (beat_cnt),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_beat(input logic [DW-1:0] base);
    logic [W-1:0] b;
    for (int i = 0; i < DS; i++) b[i*DW +: DW] = base + DW'(i);
    return b;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_sb();
    for (int i = 0; i < DS; i++) exp_q[i].delete();
  endtask

  // scoreboard: pops per-lane expectations on each lane handshake, queues each accepted beat
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < DS; i++) begin
        if (dout_s_tvalid[i] && dout_s_tready[i]) begin
          if (exp_q[i].size() == 0)
            check_eq($sformatf("lane%0d_extra_take", i), W'(exp_q[i].size()), W'(1));
          else
            check_eq($sformatf("lane%0d_data", i), W'(dout_s_tdata[i*DW +: DW]), W'(exp_q[i].pop_front()));
        end
      end
      if (din_s_tvalid && din_s_tready) begin
        for (int i = 0; i < DS; i++) begin
`ifdef FORK_LANE_MASK_EN
          exp_q[i].push_back(lane_mask[i] ? '0 : din_s_tdata[i*DW +: DW]);
`else
          exp_q[i].push_back(din_s_tdata[i*DW +: DW]);
`endif
        end
      end
    end
  end

  initial begin
    int r [DS];
    int last;
    logic [DS-1:0] exp_v;
    din_s_tvalid  = 1'b0;
    din_s_tdata   = '0;
    dout_s_tready = '0;
`ifdef FORK_LANE_MASK_EN
    lane_mask     = '0;
`endif

    // reset then idle
    #2 rstn = 1'b0;
    repeat (5) step();
    check_eq("rst_tready", W'(din_s_tready), W'(0));
    check_eq("rst_tvalid", W'(dout_s_tvalid), W'(0));
    check_eq("rst_tdata", dout_s_tdata, '0);
    check_eq("rst_busy", W'(busy), W'(0));
    check_eq("rst_cnt", W'(beat_cnt), W'(0));
    rstn = 1'b1;
    step();
    check_eq("idle_tready", W'(din_s_tready), W'(1));
    check_eq("idle_busy", W'(busy), W'(0));
    check_eq("idle_cnt", W'(beat_cnt), W'(0));

    // streaming: 8 beats back-to-back, all lanes ready
    dout_s_tready = '1;
    din_s_tvalid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din_s_tdata = mk_beat(DW'(16'h3C00 + 16 * k));
      step();
      check_eq("stream_tready", W'(din_s_tready), W'(1));
      if (k == 0) begin
        check_eq("stream_first_valid", W'(dout_s_tvalid), W'({DS{1'b1}}));
        check_eq("stream_first_data", dout_s_tdata, mk_beat(16'h3C00));
        check_eq("stream_busy", W'(busy), W'(1));
      end
    end
    din_s_tvalid = 1'b0;
    step();
    check_eq("stream_cnt", W'(beat_cnt), W'(8));
    check_eq("stream_idle_busy", W'(busy), W'(0));
    check_eq("stream_idle_valid", W'(dout_s_tvalid), W'(0));

    // single-lane stall: lane 5 not ready for 6 cycles, 4 beats offered
    dout_s_tready = 16'hFFDF;
    din_s_tvalid  = 1'b1;
    din_s_tdata   = mk_beat(16'h4100);
    step();
    check_eq("stall_v_first", W'(dout_s_tvalid), W'(16'hFFFF));
    din_s_tdata = mk_beat(16'h4110);
    step();
    check_eq("stall_v_lane5", W'(dout_s_tvalid), W'(16'h0020));
    check_eq("stall_tready_lo", W'(din_s_tready), W'(0));
    check_eq("stall_busy", W'(busy), W'(1));
    din_s_tdata = mk_beat(16'h4120);
    repeat (4) step();
    check_eq("stall_v_hold", W'(dout_s_tvalid), W'(16'h0020));
    check_eq("stall_tready_hold", W'(din_s_tready), W'(0));
    check_eq("stall_data_hold", dout_s_tdata, mk_beat(16'h4100));
    check_eq("stall_cnt_hold", W'(beat_cnt), W'(8));
    dout_s_tready = '1;
    step();
    check_eq("release_tready", W'(din_s_tready), W'(1));
    check_eq("release_valid", W'(dout_s_tvalid), W'(16'hFFFF));
    check_eq("release_data", dout_s_tdata, mk_beat(16'h4110));
    check_eq("release_cnt", W'(beat_cnt), W'(9));
    step();
    din_s_tdata = mk_beat(16'h4130);
    step();
    din_s_tvalid = 1'b0;
    step();
    check_eq("stall_cnt_final", W'(beat_cnt), W'(12));
    check_eq("stall_busy_final", W'(busy), W'(0));

    // staggered readies within a 10-cycle window
    for (int it = 0; it < 2; it++) begin
      last = 0;
      for (int i = 0; i < DS; i++) begin
        r[i] = int'($urandom_range(0, 9));
        if (r[i] > last) last = r[i];
      end
      dout_s_tready = '0;
      din_s_tvalid  = 1'b1;
      din_s_tdata   = mk_beat(DW'(16'h4200 + 16'h20 * it));
      step();
      din_s_tvalid = 1'b0;
      check_eq("stag_valid_start", W'(dout_s_tvalid), W'(16'hFFFF));
      for (int c = 0; c < 10; c++) begin
        for (int i = 0; i < DS; i++) dout_s_tready[i] = (c >= r[i]);
        step();
        exp_v = '0;
        for (int i = 0; i < DS; i++) exp_v[i] = (c < last) && (r[i] > c);
        check_eq($sformatf("stag%0d_valid_c%0d", it, c), W'(dout_s_tvalid), W'(exp_v));
        check_eq($sformatf("stag%0d_cnt_c%0d", it, c), W'(beat_cnt), W'((c >= last) ? 13 + it : 12 + it));
      end
    end

    // reset mid-stall with two entries held and lane 5 outstanding
    dout_s_tready = 16'hFFDF;
    din_s_tvalid  = 1'b1;
    din_s_tdata   = mk_beat(16'h4300);
    step();
    din_s_tdata = mk_beat(16'h4310);
    step();
    din_s_tvalid = 1'b0;
    check_eq("mid_busy_pre", W'(busy), W'(1));
    #1 rstn = 1'b0;
    #1;
    check_eq("mid_rst_valid", W'(dout_s_tvalid), W'(0));
    check_eq("mid_rst_tready", W'(din_s_tready), W'(0));
    check_eq("mid_rst_busy", W'(busy), W'(0));
    check_eq("mid_rst_cnt", W'(beat_cnt), W'(0));
    check_eq("mid_rst_tdata", dout_s_tdata, '0);
    flush_sb();
    step();
    step();
    rstn = 1'b1;
    step();
    check_eq("mid_rel_tready", W'(din_s_tready), W'(1));
    dout_s_tready = '1;
    din_s_tvalid  = 1'b1;
    din_s_tdata   = {DS{16'h4000}};
    step();
    din_s_tvalid = 1'b0;
    check_eq("mid_new_valid", W'(dout_s_tvalid), W'(16'hFFFF));
    check_eq("mid_new_data", dout_s_tdata, {DS{16'h4000}});
    step();
    check_eq("mid_new_cnt", W'(beat_cnt), W'(1));
    check_eq("mid_new_busy", W'(busy), W'(0));

`ifdef FORK_LANE_MASK_EN
    begin
      logic [W-1:0] exp_d;
      lane_mask    = 16'h00F0;
      din_s_tvalid = 1'b1;
      din_s_tdata  = {DS{16'h3C00}};
      step();
      din_s_tvalid = 1'b0;
      lane_mask    = '0;
      for (int i = 0; i < DS; i++) exp_d[i*DW +: DW] = (i >= 4 && i <= 7) ? 16'h0000 : 16'h3C00;
      check_eq("mask_data", dout_s_tdata, exp_d);
      step();
      check_eq("mask_cnt", W'(beat_cnt), W'(2));
    end
`endif

    repeat (2) step();
    for (int i = 0; i < DS; i++)
      check_eq($sformatf("lane%0d_sb_drain", i), W'(exp_q[i].size()), W'(0));

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
